riscv_str_op_unit: RTL and testbench
====================================

# riscv_str_op_unit

Byte-serial execution unit for the custom string-operation opcode (OPCODE_STR_OPS, 7'h0b). It sits in the EX stage beside the ALU and takes the STR_OP_* operator and rs1 operand from the ID stage. It rewrites the four packed ASCII bytes of the operand one byte per cycle and hands the 32-bit result to write-back through a valid/ready handshake. Processing stops early at a NUL byte.

## Interface
- STR_OP_WIDTH, 2: operator width (package constant, not overridable).
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low. One clock; reset is asynchronous and active-low.
- enable_i  in  1  request from ID; the operation is accepted when enable_i && ready_o.
- operator_i  in  2  STR_OP_UPPER/LOWER/LEET/ROT13; sampled only on accept.
- operand_a_i  in  32  rs1; byte 0 = bits [7:0], processed first; sampled only on accept.
- kill_i  in  1  pipeline flush; aborts any operation.
- ex_ready_i  in  1  write-back is able to take the result.
- ready_o  out  1  unit idle and able to accept.
- valid_o  out  1  result_o and illegal_o are valid.
- result_o  out  32  transformed word.
- illegal_o  out  1  operator not supported in this build; qualified by valid_o.

## Operation
- FSM states: IDLE, BUSY, DONE. The reset state is IDLE.
- IDLE:
  - ready_o=1.
  - On accept, latch the operand into the result register and the operator into the op register, set byte index idx=0, and go to BUSY.
- BUSY: each cycle, replace byte[idx] with xlate(byte[idx], op), then:
  - If byte[idx]==8'h00, or idx==3, go to DONE.
  - Otherwise idx++.
  - A NUL byte is left as 8'h00. Bytes above it are copied unchanged.
- DONE:
  - valid_o=1.
  - Hold result_o until ex_ready_i=1, then go to IDLE.
  - enable_i is ignored in DONE and BUSY.
- kill_i has priority over every other transition: the next state is IDLE and valid_o is deasserted. result_o keeps its stale value.
- xlate (byte-wise; every non-listed byte is unchanged):
  - UPPER: 8'h61–8'h7A minus 8'h20.
  - LOWER: 8'h41–8'h5A plus 8'h20.
  - ROT13: letters rotated by 13 within their own case, modulo 26 (for example 'z'→'m').
  - LEET: case-insensitive substitution a→8'h34, e→8'h33, i→8'h31, o→8'h30, s→8'h35, t→8'h37.
- Arithmetic is 8-bit only. No carries between bytes.
- Reset values: result_o=32'h0, valid_o=0, illegal_o=0, ready_o=1, idx=0.
- Reset asserted mid-operation returns the unit to IDLE immediately; no result is produced.

## Timing
- Accept edge E0. Bytes are processed on edges E1..E(k+1), where k is the index of the first NUL byte (k=3 if there is none).
- valid_o rises after E(k+1). Latency is k+1 cycles: minimum 1, maximum 4.
- The handshake completes on the edge where valid_o && ex_ready_i. ready_o=1 from the following cycle.
- Minimum issue interval is latency+2 cycles when ex_ready_i is held high.
- No combinational path from any input to any output. ready_o, valid_o and illegal_o are decoded from registered state.

## Configuration
- RISCV_STR_LEET_EN defined: LEET is fully supported and illegal_o stays 0.
- RISCV_STR_LEET_EN undefined: the LEET logic is not compiled. A LEET request is still accepted and goes IDLE→BUSY→DONE in exactly 1 cycle with result_o=operand. illegal_o=1 while valid_o=1. The controller raises the illegal-instruction exception (EXC_CAUSE_ILLEGAL_INSN).

## Structure
- Shared package riscv_defines (existing package): STR_OP_* constants and OPCODE_STR_OPS already live there. Add to it:
  - str_state_t, a 2-bit enum for IDLE/BUSY/DONE.
  - STR_LEET_* 8-bit substitution constants.
  - STR_CASE_DELTA = 8'h20.
- Sub-module riscv_str_byte_xlate: purely combinational, byte_i[7:0] + op_i → byte_o. The LEET branch sits under the same macro.
- Top-level riscv_str_op_unit: FSM, index counter, result register. The byte mux writes at idx.

## Test plan
- UPPER, 32'h64636261 ("abcd"), ex_ready_i=1 → result 32'h44434241, valid_o after 4 cycles, illegal_o=0.
- ROT13, 32'h7A6E4D41 ("AMnz") → 32'h6D615A4E, latency 4.
- LEET, 32'h74736F65:
  - With the macro: → 32'h37353033.
  - Without the macro: → 32'h74736F65 with illegal_o=1, latency 1.
- LOWER, 32'h41004142 → 32'h41006162 with latency 3. The NUL byte stops processing and byte 3 is untouched.
- Stall and kill:
  - ex_ready_i=0 for 5 cycles in DONE: result_o and valid_o are held stable, and enable_i is ignored.
  - kill_i in the 2nd BUSY cycle: ready_o=1 next cycle and valid_o never rises.
- Assert rst_n low mid-BUSY: all outputs take their reset values asynchronously. A new request after reset is accepted normally.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared RISC-V core definitions: opcodes, string-op operators, exception causes and the
// string-op unit's FSM state type and byte-translation constants.
package riscv_defines;

    localparam logic [6:0] OPCODE_STR_OPS = 7'h0b;

    localparam int unsigned STR_OP_WIDTH = 2;

    localparam logic [STR_OP_WIDTH-1:0] STR_OP_UPPER = 2'd0;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER = 2'd1;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_LEET  = 2'd2;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_ROT13 = 2'd3;

    localparam logic [5:0] EXC_CAUSE_ILLEGAL_INSN = 6'h02;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } str_state_t;

    localparam logic [7:0] STR_LEET_A = 8'h34;
    localparam logic [7:0] STR_LEET_E = 8'h33;
    localparam logic [7:0] STR_LEET_I = 8'h31;
    localparam logic [7:0] STR_LEET_O = 8'h30;
    localparam logic [7:0] STR_LEET_S = 8'h35;
    localparam logic [7:0] STR_LEET_T = 8'h37;

    localparam logic [7:0] STR_CASE_DELTA = 8'h20;

endpackage

// File: rtl/riscv_str_byte_xlate.sv
// Combinational single-byte ASCII translator for the string-op unit.
// The LEET substitution is only built when RISCV_STR_LEET_EN is defined.
module riscv_str_byte_xlate
    import riscv_defines::*;
(
    input  logic [7:0]              byte_i,
    input  logic [STR_OP_WIDTH-1:0] op_i,
    output logic [7:0]              byte_o
);

    logic       is_upper;
    logic       is_lower;
    logic [7:0] base;
    logic [7:0] rot_off;
`ifdef RISCV_STR_LEET_EN
    logic [7:0] folded;
`endif

    assign is_upper = (byte_i >= 8'h41) && (byte_i <= 8'h5a);
    assign is_lower = (byte_i >= 8'h61) && (byte_i <= 8'h7a);

    // Translate one byte; anything outside the operator's alphabet passes through.
    always_comb begin
        byte_o  = byte_i;
        base    = is_upper ? 8'h41 : 8'h61;
        rot_off = byte_i - base + 8'd13;
        if (rot_off >= 8'd26) begin
            rot_off = rot_off - 8'd26;
        end
`ifdef RISCV_STR_LEET_EN
        folded = is_upper ? byte_i + STR_CASE_DELTA : byte_i;
`endif
        case (op_i)
            STR_OP_UPPER: if (is_lower) byte_o = byte_i - STR_CASE_DELTA;
            STR_OP_LOWER: if (is_upper) byte_o = byte_i + STR_CASE_DELTA;
            STR_OP_ROT13: if (is_upper || is_lower) byte_o = base + rot_off;
`ifdef RISCV_STR_LEET_EN
            STR_OP_LEET: begin
                case (folded)
                    8'h61:   byte_o = STR_LEET_A;
                    8'h65:   byte_o = STR_LEET_E;
                    8'h69:   byte_o = STR_LEET_I;
                    8'h6f:   byte_o = STR_LEET_O;
                    8'h73:   byte_o = STR_LEET_S;
                    8'h74:   byte_o = STR_LEET_T;
                    default: byte_o = byte_i;
                endcase
            end
`endif
            default: byte_o = byte_i;
        endcase
    end

endmodule

// File: rtl/riscv_str_op_unit.sv
// Byte-serial string-operation unit (OPCODE_STR_OPS) in the EX stage.
// Rewrites the four bytes of rs1 one per cycle, stopping at the first NUL, and hands the
// word to write-back via valid/ready. Macro RISCV_STR_LEET_EN enables the LEET operator;
// without it a LEET request completes in one cycle unchanged and flags illegal_o.
module riscv_str_op_unit
    import riscv_defines::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic [STR_OP_WIDTH-1:0] operator_i,
    input  logic [31:0]             operand_a_i,
    input  logic                    kill_i,
    input  logic                    ex_ready_i,
    output logic                    ready_o,
    output logic                    valid_o,
    output logic [31:0]             result_o,
    output logic                    illegal_o
);

    str_state_t              state_q, state_d;
    logic [STR_OP_WIDTH-1:0] op_q, op_d;
    logic [1:0]              idx_q, idx_d;
    logic [31:0]             result_q, result_d;
    logic [7:0]              cur_byte;
    logic [7:0]              new_byte;
    logic                    last_byte;
    logic                    leet_bypass;

    assign cur_byte  = result_q[{idx_q, 3'b000} +: 8];
    assign last_byte = (cur_byte == 8'h00) || (idx_q == 2'd3);

`ifdef RISCV_STR_LEET_EN
    assign leet_bypass = 1'b0;
`else
    // Unsupported LEET: skip the byte walk and report illegal on completion.
    assign leet_bypass = (op_q == STR_OP_LEET);
`endif

    riscv_str_byte_xlate u_xlate (
        .byte_i (cur_byte),
        .op_i   (op_q),
        .byte_o (new_byte)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a kill overrides every other transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable_i) state_d = StBusy;
            StBusy:  if (leet_bypass || last_byte) state_d = StDone;
            StDone:  if (ex_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (kill_i) begin
            state_d = StIdle;
        end
    end

    // FSM outputs, decoded from registered state only.
    always_comb begin
        ready_o   = (state_q == StIdle);
        valid_o   = (state_q == StDone);
        illegal_o = (state_q == StDone) && leet_bypass;
    end

    // Datapath next state: load on accept, overwrite byte[idx] while busy.
    always_comb begin
        result_d = result_q;
        op_d     = op_q;
        idx_d    = idx_q;
        if (!kill_i) begin
            if (state_q == StIdle && enable_i) begin
                result_d = operand_a_i;
                op_d     = operator_i;
                idx_d    = 2'd0;
            end else if (state_q == StBusy && !leet_bypass) begin
                result_d[{idx_q, 3'b000} +: 8] = new_byte;
                if (!last_byte) begin
                    idx_d = idx_q + 2'd1;
                end
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= 32'h0;
            op_q     <= STR_OP_UPPER;
            idx_q    <= 2'd0;
        end else begin
            result_q <= result_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_riscv_str_op_unit.sv
// Self-checking bench for riscv_str_op_unit: directed cases, stall/kill/reset scenarios and
// randomized traffic checked every cycle against a transaction-level model.
module tb_riscv_str_op_unit;
    import riscv_defines::*;

`ifdef RISCV_STR_LEET_EN
    localparam bit LeetEn = 1'b1;
`else
    localparam bit LeetEn = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        enable_i;
    logic [1:0]  operator_i;
    logic [31:0] operand_a_i;
    logic        kill_i;
    logic        ex_ready_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic        illegal_o;

    int total = 0;
    int bad   = 0;

    riscv_str_op_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable_i    (enable_i),
        .operator_i  (operator_i),
        .operand_a_i (operand_a_i),
        .kill_i      (kill_i),
        .ex_ready_i  (ex_ready_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .result_o    (result_o),
        .illegal_o   (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] m_char(input logic [1:0] op, input logic [7:0] b);
        int c  = int'(b);
        int lc = (c >= 65 && c <= 90) ? c + 32 : c;
        case (op)
            STR_OP_UPPER: if (c >= 97 && c <= 122) return 8'(c - 32);
            STR_OP_LOWER: if (c >= 65 && c <= 90) return 8'(c + 32);
            STR_OP_ROT13: begin
                if (c >= 65 && c <= 90) return 8'((c - 65 + 13) % 26 + 65);
                if (c >= 97 && c <= 122) return 8'((c - 97 + 13) % 26 + 97);
            end
            default: begin
                if (lc == 97)  return 8'h34;
                if (lc == 101) return 8'h33;
                if (lc == 105) return 8'h31;
                if (lc == 111) return 8'h30;
                if (lc == 115) return 8'h35;
                if (lc == 116) return 8'h37;
            end
        endcase
        return b;
    endfunction

    function automatic bit m_ill(input logic [1:0] op);
        return (op == STR_OP_LEET) && !LeetEn;
    endfunction

    function automatic logic [31:0] m_word(input logic [1:0] op, input logic [31:0] w);
        logic [31:0] r = w;
        if (m_ill(op)) return w;
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = m_char(op, w[i*8 +: 8]);
            if (w[i*8 +: 8] == 8'h00) break;
        end
        return r;
    endfunction

    function automatic int m_lat(input logic [1:0] op, input logic [31:0] w);
        if (m_ill(op)) return 1;
        for (int i = 0; i < 4; i++) begin
            if (w[i*8 +: 8] == 8'h00) return i + 1;
        end
        return 4;
    endfunction

    // Transaction-level model: cycles remaining until the result appears, then hold until taken.
    int          m_cnt;
    logic        m_valid;
    logic [31:0] m_res, m_final;
    logic        m_illegal, m_ill_next;
    wire         m_ready = (m_cnt == 0) && !m_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt     <= 0;
            m_valid   <= 1'b0;
            m_res     <= 32'h0;
            m_illegal <= 1'b0;
        end else if (kill_i) begin
            m_cnt   <= 0;
            m_valid <= 1'b0;
        end else if (m_ready && enable_i) begin
            m_cnt      <= m_lat(operator_i, operand_a_i);
            m_final    <= m_word(operator_i, operand_a_i);
            m_ill_next <= m_ill(operator_i);
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_valid   <= 1'b1;
                m_res     <= m_final;
                m_illegal <= m_ill_next;
            end
        end else if (m_valid && ex_ready_i) begin
            m_valid <= 1'b0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready", 32'(ready_o), 32'(m_ready));
            chk("valid", 32'(valid_o), 32'(m_valid));
            if (m_valid) begin
                chk("result", result_o, m_res);
                chk("illegal", 32'(illegal_o), 32'(m_illegal));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ready();
        for (int i = 0; i < 20 && !ready_o; i++) @(negedge clk);
        if (!ready_o) chk("wait_ready_timeout", 32'(ready_o), 32'd1);
    endtask

    task automatic run_txn(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] exp_res, input int exp_lat, input logic exp_ill);
        int cyc = 0;
        bit got = 0;
        wait_ready();
        operator_i  = op;
        operand_a_i = a;
        enable_i    = 1'b1;
        ex_ready_i  = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            enable_i    = 1'b0;
            operator_i  = 2'($urandom);
            operand_a_i = $urandom;
            cyc++;
            if (valid_o) got = 1;
        end
        chk({name, "_lat"}, got ? 32'(cyc - 1) : 32'hffffffff, 32'(exp_lat));
        chk({name, "_res"}, result_o, exp_res);
        chk({name, "_ill"}, 32'(illegal_o), 32'(exp_ill));
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            w[i*8 +: 8] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(32, 126));
        end
        return w;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] held;
        rst_n       = 1'b0;
        enable_i    = 1'b0;
        operator_i  = STR_OP_UPPER;
        operand_a_i = 32'h0;
        kill_i      = 1'b0;
        ex_ready_i  = 1'b1;

        // Model pins against hand-computed words.
        chk("pin_upper", m_word(STR_OP_UPPER, 32'h64636261), 32'h44434241);
        chk("pin_rot13", m_word(STR_OP_ROT13, 32'h7A6E4D41), 32'h6D615A4E);
        chk("pin_lower", m_word(STR_OP_LOWER, 32'h41004142), 32'h41006162);
        chk("pin_lower_lat", 32'(m_lat(STR_OP_LOWER, 32'h41004142)), 32'd3);
        chk("pin_leet", m_word(STR_OP_LEET, 32'h74736F65), LeetEn ? 32'h37353033 : 32'h74736F65);

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_result", result_o, 32'h0);
        chk("rst_illegal", 32'(illegal_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn("upper", STR_OP_UPPER, 32'h64636261, 32'h44434241, 4, 1'b0);
        run_txn("rot13", STR_OP_ROT13, 32'h7A6E4D41, 32'h6D615A4E, 4, 1'b0);
        if (LeetEn) run_txn("leet", STR_OP_LEET, 32'h74736F65, 32'h37353033, 4, 1'b0);
        else        run_txn("leet", STR_OP_LEET, 32'h74736F65, 32'h74736F65, 1, 1'b1);
        run_txn("lower_nul", STR_OP_LOWER, 32'h41004142, 32'h41006162, 3, 1'b0);
        run_txn("nul_first", STR_OP_UPPER, 32'h61616100, 32'h61616100, 1, 1'b0);

        // Stall in DONE with enable_i held high: result and valid must not move.
        wait_ready();
        operator_i  = STR_OP_UPPER;
        operand_a_i = 32'h7a797877;
        enable_i    = 1'b1;
        ex_ready_i  = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10 && !valid_o; i++) @(negedge clk);
        held = result_o;
        chk("stall_res", held, 32'h5a595857);
        for (int i = 0; i < 5; i++) begin
            operand_a_i = $urandom;
            @(negedge clk);
            chk("stall_valid", 32'(valid_o), 32'd1);
            chk("stall_hold", result_o, held);
        end
        enable_i   = 1'b0;
        ex_ready_i = 1'b1;
        @(negedge clk);

        // Kill during the second BUSY cycle.
        wait_ready();
        operator_i  = STR_OP_ROT13;
        operand_a_i = 32'h64636261;
        enable_i    = 1'b1;
        @(negedge clk);
        enable_i = 1'b0;
        @(negedge clk);
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        chk("kill_ready", 32'(ready_o), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("kill_novalid", 32'(valid_o), 32'd0);
        end

        // Asynchronous reset in the middle of BUSY.
        wait_ready();
        operator_i  = STR_OP_LOWER;
        operand_a_i = 32'h44434241;
        enable_i    = 1'b1;
        @(negedge clk);
        enable_i = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(ready_o), 32'd1);
        chk("arst_valid", 32'(valid_o), 32'd0);
        chk("arst_result", result_o, 32'h0);
        chk("arst_illegal", 32'(illegal_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn("after_rst", STR_OP_LOWER, 32'h44434241, 32'h64636261, 4, 1'b0);

        // Randomized traffic, checked every cycle by the model comparator.
        for (int i = 0; i < 600; i++) begin
            enable_i    = 1'($urandom);
            operator_i  = 2'($urandom);
            operand_a_i = rand_word();
            ex_ready_i  = ($urandom_range(0, 3) != 0);
            kill_i      = ($urandom_range(0, 31) == 0);
            @(negedge clk);
        end
        enable_i   = 1'b0;
        kill_i     = 1'b0;
        ex_ready_i = 1'b1;
        repeat (8) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
